// File: rtl/axis_pkg.sv
// Shared defaults and beat layout for the AXI-Stream slave receive path.
package axis_pkg;

  localparam int AXIS_DATA_WIDTH_DEF = 32;
  localparam int AXIS_FIFO_DEPTH_DEF = 4;

  typedef struct packed {
    logic                           last;
    logic [AXIS_DATA_WIDTH_DEF-1:0] data;
  } axis_beat_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Generic synchronous FIFO with a first-word-fall-through read port.
// Writes while full and reads while empty are dropped.
module axis_sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_fire, rd_fire;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_fire = wr_en & ~full;
  assign rd_fire = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge aclk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/axis_s_rx.sv
// AXI-Stream slave: buffers beats in a FWFT FIFO, registered backpressure.
// Optional packet counter enabled by defining AXIS_S_RX_PKT_CNT_EN.
module axis_s_rx
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH_DEF,
  parameter int DEPTH      = AXIS_FIFO_DEPTH_DEF,
  parameter int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [CNT_W-1:0]      count,
  output logic                  received,
`ifdef AXIS_S_RX_PKT_CNT_EN
  input  logic                  pkt_cnt_clr,
  output logic [15:0]           pkt_cnt,
`endif
  output logic                  err_underflow
);

  logic                s_tready_q, s_tready_d;
  logic                received_q, received_d;
  logic                err_q, err_d;
  logic                accept, empty, full;
  logic [CNT_W-1:0]    count_nxt;
  logic [DATA_WIDTH:0] head;

  assign accept = s_tvalid & s_tready_q & ~full;

  axis_sync_fifo #(
    .W     (DATA_WIDTH + 1),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .wr_en     (accept),
    .wr_data   ({s_tlast, s_tdata}),
    .rd_en     (rd_en),
    .rd_data   (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .count_nxt (count_nxt)
  );

  // Ready looks at next occupancy so a pop frees space one cycle later.
  always_comb begin
    s_tready_d = (count_nxt < CNT_W'(DEPTH));
    received_d = accept & s_tlast;
    err_d      = err_q | (rd_en & empty);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      s_tready_q <= 1'b0;
      received_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s_tready_q <= s_tready_d;
      received_q <= received_d;
      err_q      <= err_d;
    end
  end

`ifdef AXIS_S_RX_PKT_CNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_cnt_clr)            pkt_cnt_d = '0;
    else if (accept && s_tlast) pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) pkt_cnt_q <= '0;
    else           pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

  assign s_tready      = s_tready_q;
  assign received      = received_q;
  assign err_underflow = err_q;
  assign rd_valid      = ~empty;
  assign rd_data       = head[DATA_WIDTH-1:0];
  assign rd_last       = head[DATA_WIDTH];

endmodule

// File: doc/axis_s_rx.md
Name: axis_s_rx

Overview:
- AXI-Stream slave stage that directly consumes the single-beat stream (tdata/tvalid/tlast) produced by the upstream AXIS master.
- Buffers accepted beats in a small synchronous FIFO and presents them to local logic through a first-word-fall-through (FWFT) read port.
- Drives tready from FIFO occupancy, so it provides backpressure to the master.
- Pulses `received` for each accepted beat that has tlast set, mirroring the master's `finish`.

Parameters:
- DATA_WIDTH, 32, tdata / rd_data width in bits.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset_n  in  1  reset; asynchronous assert, active-low.
- s_tvalid  in  1  upstream beat valid.
- s_tready  out  1  slave ready (backpressure).
- s_tdata  in  DATA_WIDTH  upstream beat data.
- s_tlast  in  1  last beat of packet.
- rd_en  in  1  pop head entry.
- rd_valid  out  1  head entry present (FWFT).
- rd_data  out  DATA_WIDTH  head entry data.
- rd_last  out  1  head entry tlast flag.
- count  out  CNT_W  entries held.
- received  out  1  one-cycle pulse, tlast beat accepted.
- err_underflow  out  1  sticky: rd_en while empty.

Behaviour:
- Reset (areset_n=0, asynchronous):
  - wr_ptr=rd_ptr=0, count=0, s_tready=0, received=0, err_underflow=0.
  - rd_valid=0; rd_data/rd_last don't-care but driven from mem[0].
  - Memory contents are not reset.
- First edge after deassertion: s_tready becomes 1. It is a register, reset to 0, and otherwise equals next_count<DEPTH.
- Accept (write):
  - A beat is accepted when s_tvalid & s_tready at a rising edge.
  - {s_tlast, s_tdata} is stored at wr_ptr and wr_ptr increments, wrapping mod DEPTH.
- Pop (read):
  - Occurs when rd_en & rd_valid at a rising edge; rd_ptr increments, wrapping mod DEPTH.
  - rd_data/rd_last are combinational from mem[rd_ptr].
  - rd_valid = (count!=0).
- Latency: a beat accepted at edge N is visible on rd_valid/rd_data immediately after edge N. There is no same-cycle pass-through.
- count:
  - +1 on accept only, −1 on pop only, unchanged when both or neither occur.
  - Never exceeds DEPTH; never wraps below 0.
- Full (count==DEPTH):
  - s_tready=0.
  - A pop in that cycle raises s_tready the following cycle, not the same cycle.
- Empty:
  - rd_en is ignored: no pointer move, no count change.
  - err_underflow is set to 1 and held until reset.
  - A simultaneous accept still writes normally.
- received: registered; 1 for exactly one cycle after each edge that accepts a beat with s_tlast=1, otherwise 0.
- s_tvalid without s_tready: the beat is not stored. Upstream holds the beat (AXI rule); this block does not check that.
- Reset mid-operation: all stored entries are discarded (count=0) and s_tready drops asynchronously.

Optional Feature:
- Macro: AXIS_S_RX_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt [15:0], reset 0.
  - Increments on every accepted beat with s_tlast=1, wraps 0xFFFF→0x0000.
  - Adds input pkt_cnt_clr; synchronous clear to 0, which takes priority over a same-cycle increment.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Package axis_pkg holds:
  - localparam AXIS_DATA_WIDTH_DEF=32.
  - AXIS_FIFO_DEPTH_DEF=4.
  - typedef struct packed {logic last; logic [AXIS_DATA_WIDTH_DEF-1:0] data;} axis_beat_t.
- Sub-module axis_sync_fifo contains the generic pointer/count/memory logic with wr_en/rd_en/full/empty/count.
- axis_s_rx wraps the FIFO with the handshake, received, error and optional counter logic.

Test Plan:
- Reset then idle:
  - areset_n low for 3 cycles, then high → s_tready=0 during reset, 1 on the first edge after release.
  - count=0, rd_valid=0, received=0.
- Single packet: s_tdata=0xA5A5_0001, s_tlast=1, s_tvalid for 1 cycle →
  - next cycle: rd_valid=1, rd_data=0xA5A5_0001, rd_last=1, count=1, received high for 1 cycle.
  - after rd_en: count=0.
- Fill/backpressure: hold s_tvalid, tdata=1,2,3,4,5, rd_en=0 →
  - accepts 1..4, count=4, s_tready=0, beat 5 held.
  - one pop → rd_data was 1; s_tready=1 next cycle; 5 accepted; order 2,3,4,5 preserved.
- Wrap-around: 10 beats 0x10..0x19 with rd_en=1 continuously → read order matches; count never exceeds 1; pointers wrap twice without loss.
- Underflow: rd_en=1 while empty → err_underflow=1 and stays 1; count stays 0; it clears only on reset.
- Reset mid-fill: 3 beats stored, areset_n pulsed low mid-cycle → count=0, s_tready=0 immediately. With AXIS_S_RX_PKT_CNT_EN defined, pkt_cnt=0 and three tlast beats give pkt_cnt=3.
